// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage MIPS pipeline.
// Holds the EX/MEM and MEM/WB registers, drives the data-memory
// request/ready handshake, aligns sub-word stores, extracts loads and
// stalls IF/ID/EX while an access is outstanding.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses
// are suppressed, flagged on the sticky 'misalign' output and retired as
// a bubble. Without the macro such accesses proceed with lane rules only.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic        EX_MemWrite,
  input  logic        EX_MemtoReg,
  input  logic [4:0]  EX_RegWriteA,
  input  logic [31:0] EX_ALUResult,
  input  logic [31:0] EX_WriteData,
  input  logic [3:0]  EX_LoadType,
  input  logic [2:0]  EX_SaveType,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        MEM_Stall,
  output logic [31:0] EX_MEM_ALUResult,
  output logic        EX_MEM_RegWrite,
  output logic [4:0]  EX_MEM_RegWriteA,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_MemtoReg,
  output logic [4:0]  MEM_WB_RegWriteA,
  output logic [31:0] MEM_WB_ALUResult,
  output logic [31:0] MEM_WB_ReadData,
  output logic        mem_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  // waitCount only needs to reach TIMEOUT-2: the IDLE cycle is the first
  // stall cycle, so WAIT covers stall cycles 2..TIMEOUT.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'((TIMEOUT > 1) ? TIMEOUT - 2 : 0);

  state_t        state;
  logic [CW-1:0] waitCount;

  logic          exMemMemRead;
  logic          exMemMemWrite;
  logic          exMemMemtoReg;
  logic [31:0]   exMemWriteData;
  logic [3:0]    exMemLoadType;
  logic [2:0]    exMemSaveType;

  logic [1:0]    byteSel;
  logic          memOp;
  logic          isLoad;
  logic          accessByte;
  logic          accessHalf;
  logic          accessWord;
  logic          misalignedOp;
  logic          reqOp;
  logic [3:0]    alignedBe;
  logic [31:0]   alignedWdata;
  logic [7:0]    laneByte;
  logic [15:0]   laneHalf;
  logic [31:0]   loadData;
  logic [31:0]   wbReadData;

  assign byteSel = EX_MEM_ALUResult[1:0];
  // A simultaneous read+write is treated as a write.
  assign memOp   = exMemMemRead | exMemMemWrite;
  assign isLoad  = exMemMemRead & ~exMemMemWrite;

  assign accessByte = exMemMemWrite ? (exMemSaveType == 3'd1)
                                    : (isLoad && (exMemLoadType == 4'd1 || exMemLoadType == 4'd2));
  assign accessHalf = exMemMemWrite ? (exMemSaveType == 3'd2)
                                    : (isLoad && (exMemLoadType == 4'd3 || exMemLoadType == 4'd4));
  assign accessWord = memOp & ~accessByte & ~accessHalf;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalignedOp = (accessHalf & byteSel[0]) | (accessWord & (byteSel != 2'b00));
`else
  assign misalignedOp = 1'b0;
`endif

  // An access that actually goes to memory.
  assign reqOp = memOp & ~misalignedOp;

  assign dmem_req  = reqOp && (state != S_DONE);
  assign MEM_Stall = reqOp && !dmem_ready && (state != S_DONE);
  assign dmem_we   = memOp & exMemMemWrite;
  assign dmem_addr = memOp ? {EX_MEM_ALUResult[31:2], 2'b00} : 32'd0;
  assign dmem_be   = alignedBe;
  assign dmem_wdata = alignedWdata;

  // Lane enables and replicated store data, derived from EX/MEM only.
  always_comb begin
    alignedBe    = 4'b0000;
    alignedWdata = 32'd0;
    if (memOp) begin
      if (exMemMemWrite) begin
        case (exMemSaveType)
          3'd1: begin
            alignedBe    = 4'b0001 << byteSel;
            alignedWdata = {4{exMemWriteData[7:0]}};
          end
          3'd2: begin
            alignedBe    = byteSel[1] ? 4'b1100 : 4'b0011;
            alignedWdata = {2{exMemWriteData[15:0]}};
          end
          default: begin
            alignedBe    = 4'b1111;
            alignedWdata = exMemWriteData;
          end
        endcase
      end else begin
        alignedBe = 4'b1111;
      end
    end
  end

  // Select the addressed lane of the read word and extend it.
  always_comb begin
    case (byteSel)
      2'd0:    laneByte = dmem_rdata[7:0];
      2'd1:    laneByte = dmem_rdata[15:8];
      2'd2:    laneByte = dmem_rdata[23:16];
      default: laneByte = dmem_rdata[31:24];
    endcase
    laneHalf = byteSel[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (exMemLoadType)
      4'd1:    loadData = {{24{laneByte[7]}}, laneByte};
      4'd2:    loadData = {24'd0, laneByte};
      4'd3:    loadData = {{16{laneHalf[15]}}, laneHalf};
      4'd4:    loadData = {16'd0, laneHalf};
      default: loadData = dmem_rdata;
    endcase
  end

  // An aborted access (DONE) and non-loads write zero read data.
  assign wbReadData = (isLoad && reqOp && state != S_DONE) ? loadData : 32'd0;

  // EX/MEM register: capture the execute stage unless memory is stalling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EX_MEM_RegWrite  <= 1'b0;
      EX_MEM_RegWriteA <= 5'd0;
      EX_MEM_ALUResult <= 32'd0;
      exMemMemRead     <= 1'b0;
      exMemMemWrite    <= 1'b0;
      exMemMemtoReg    <= 1'b0;
      exMemWriteData   <= 32'd0;
      exMemLoadType    <= 4'd0;
      exMemSaveType    <= 3'd0;
    end else if (!MEM_Stall) begin
      EX_MEM_RegWrite  <= EX_RegWrite;
      EX_MEM_RegWriteA <= EX_RegWriteA;
      EX_MEM_ALUResult <= EX_ALUResult;
      exMemMemRead     <= EX_MemRead;
      exMemMemWrite    <= EX_MemWrite;
      exMemMemtoReg    <= EX_MemtoReg;
      exMemWriteData   <= EX_WriteData;
      exMemLoadType    <= EX_LoadType;
      exMemSaveType    <= EX_SaveType;
    end
  end

  // Handshake FSM: wait for ready, abort after TIMEOUT stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      waitCount <= '0;
      mem_err   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign  <= 1'b0;
`endif
    end else begin
`ifdef MEM_MISALIGN_TRAP_EN
      if (misalignedOp) begin
        misalign <= 1'b1;
      end
`endif
      case (state)
        S_IDLE: begin
          if (reqOp && !dmem_ready) begin
            waitCount <= '0;
            if (TIMEOUT <= 1) begin
              state   <= S_DONE;
              mem_err <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem_ready) begin
            state     <= S_IDLE;
            waitCount <= '0;
          end else if (waitCount == LAST_WAIT) begin
            state   <= S_DONE;
            mem_err <= 1'b1;
          end else begin
            waitCount <= waitCount + CW'(1);
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          waitCount <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, otherwise retire EX/MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEM_WB_RegWrite  <= 1'b0;
      MEM_WB_MemtoReg  <= 1'b0;
      MEM_WB_RegWriteA <= 5'd0;
      MEM_WB_ALUResult <= 32'd0;
      MEM_WB_ReadData  <= 32'd0;
    end else if (MEM_Stall) begin
      MEM_WB_RegWrite <= 1'b0;
    end else begin
      MEM_WB_RegWrite  <= EX_MEM_RegWrite & ~misalignedOp;
      MEM_WB_MemtoReg  <= exMemMemtoReg;
      MEM_WB_RegWriteA <= EX_MEM_RegWriteA;
      MEM_WB_ALUResult <= EX_MEM_ALUResult;
      MEM_WB_ReadData  <= wbReadData;
    end
  end

endmodule
